if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the instruction-memory address.
- Selects the next PC from three sources: sequential PC+4, taken branch from EX, and jump target from the ID-stage jump-address unit.
- Registers the fetched word and its PC+4 into the IF/ID pipeline register; the ID-stage jump-address unit consumes both.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID as a bubble (sll $0,$0,0).
- CNT_W, 32, width of performance counters (only with IF_PERF_CNT_EN).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inStall  in  1  hazard-unit hold request (load-use); freezes PC and IF/ID.
- inBranchTaken  in  1  EX-stage branch resolved taken.
- inBranchTarget  in  32  EX-stage branch target.
- inJump  in  1  ID-stage jump decode (J/JAL).
- inJumpTarget  in  32  ID-stage jump target {PC+4[31:28], instr[25:0], 2'b00}.
- inImemReady  in  1  instruction memory has valid data for outImemAddr this cycle.
- inImemData  in  32  instruction word at outImemAddr.
- outImemAddr  out  32  current PC; combinational from the PC register.
- outInstruction  out  32  IF/ID instruction.
- outPostPc  out  32  IF/ID PC+4 of that instruction.
- outValid  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC.
  - outInstruction=NOP_INSTR, outPostPc=0, outValid=0.
  - Counters=0.
  - Reset asserted mid-cycle takes effect immediately and discards any in-flight redirect.
- Redirect priority, evaluated each cycle:
  - inBranchTaken beats inJump, because the EX instruction is older.
  - redirect = inBranchTaken | inJump.
  - Target low 2 bits are forced to 00.
- Per-cycle action, first match wins:
  1. redirect: PC <= target; IF/ID <= bubble. This overrides inStall and ignores inImemReady.
  2. inStall: PC and IF/ID hold all values.
  3. !inImemReady: PC holds; IF/ID <= bubble.
  4. normal: outInstruction <= inImemData; outPostPc <= PC+4; outValid <= 1; PC <= PC+4.
- Bubble definition: outInstruction=NOP_INSTR, outPostPc=0, outValid=0.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Latency: an instruction appears on the IF/ID outputs 1 cycle after its address is presented with inImemReady=1.
- Redirect penalty:
  - Jump costs 1 bubble.
  - Branch costs 1 bubble at IF/ID.
  - Squashing the ID instruction on a branch is the hazard unit's job (ID/EX flush), not this block's.
- Simultaneous branch and jump: the branch target wins; the jump is discarded because it is wrong-path.
- The PC register updates only on clk, so outImemAddr is glitch-free and does not depend on same-cycle inputs.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined:
  - Adds ports outFetchCount (out, CNT_W) and outBubbleCount (out, CNT_W).
  - outFetchCount increments on every normal load (rule 4).
  - outBubbleCount increments on every bubble load (rules 1 and 3); stall cycles are not counted.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package if_pkg holds:
  - Constants: NOP_INSTR default, PC_STEP=4, INSTR_W=32.
  - Enum next_pc_sel_t {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_HOLD}.
- Sub-module if_next_pc_mux (combinational priority select plus alignment) is natural; PC and IF/ID registers stay in the top module.

Test Plan:
- Reset then 3 cycles, ready=1, imem returns 0x20080001/0x20090002/0x200A0003 -> addr 0x0,0x4,0x8; IF/ID shows (0x20080001, postPc 0x4, valid 1), then (…, 0x8), (…, 0xC).
- PC=0x10, inJump=1 with target 0x0040_0020 -> next cycle addr 0x0040_0020, IF/ID bubble (valid 0, instr 0); following cycle fetches 0x0040_0020, postPc 0x0040_0024.
- inBranchTaken=1 (target 0x100) and inJump=1 (target 0x200) together, with inStall=1 -> PC=0x100, bubble; the stall is ignored.
- inStall=1 for 2 cycles at PC=0x8 -> addr stays 0x8; IF/ID keeps its previous instruction and valid=1; release resumes at 0x8.
- inImemReady=0 for 1 cycle at PC=0x20 -> PC holds 0x20, one bubble, then the instruction at 0x20 is delivered; with IF_PERF_CNT_EN the bubble count increments by 1.
- Force PC to 0xFFFF_FFFC via branch target, normal fetch -> postPc=0x0, next addr 0x0; assert rst_n=0 mid-cycle -> outputs clear immediately.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package if_pkg;

  localparam int unsigned INSTR_W           = 32;
  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_HOLD   = 2'd3
  } next_pc_sel_t;

  function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_next_pc_mux.sv
// Next-PC priority select: branch (older, from EX) > jump (ID) > hold > sequential.
module if_next_pc_mux
  import if_pkg::*;
(
  input  logic [INSTR_W-1:0] i_pc,
  input  logic               i_stall,
  input  logic               i_imem_ready,
  input  logic               i_branch_taken,
  input  logic [INSTR_W-1:0] i_branch_target,
  input  logic               i_jump,
  input  logic [INSTR_W-1:0] i_jump_target,
  output logic [1:0]         o_sel,
  output logic [INSTR_W-1:0] o_next_pc,
  output logic [INSTR_W-1:0] o_pc_plus4
);

  next_pc_sel_t       w_sel;
  logic [INSTR_W-1:0] w_pc_plus4;

  assign w_pc_plus4 = i_pc + PC_STEP;

  always_comb begin
    w_sel     = SEL_SEQ;
    o_next_pc = w_pc_plus4;
    if (i_branch_taken) begin
      w_sel     = SEL_BRANCH;
      o_next_pc = align_word(i_branch_target);
    end else if (i_jump) begin
      w_sel     = SEL_JUMP;
      o_next_pc = align_word(i_jump_target);
    end else if (i_stall || !i_imem_ready) begin
      w_sel     = SEL_HOLD;
      o_next_pc = i_pc;
    end
  end

  assign o_sel      = w_sel;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: PC register, next-PC selection and IF/ID pipeline register.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
`ifdef IF_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W     = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inStall,
  input  logic        inBranchTaken,
  input  logic [31:0] inBranchTarget,
  input  logic        inJump,
  input  logic [31:0] inJumpTarget,
  input  logic        inImemReady,
  input  logic [31:0] inImemData,
  output logic [31:0] outImemAddr,
  output logic [31:0] outInstruction,
  output logic [31:0] outPostPc,
`ifdef IF_PERF_CNT_EN
  output logic [CNT_W-1:0] outFetchCount,
  output logic [CNT_W-1:0] outBubbleCount,
`endif
  output logic        outValid
);

  logic [INSTR_W-1:0] r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_post_pc;
  logic               r_valid;

  logic [1:0]         w_sel_raw;
  next_pc_sel_t       w_sel;
  logic [INSTR_W-1:0] w_next_pc;
  logic [INSTR_W-1:0] w_pc_plus4;
  logic               w_load_fetch;
  logic               w_load_bubble;

  if_next_pc_mux u_next_pc_mux (
    .i_pc            (r_pc),
    .i_stall         (inStall),
    .i_imem_ready    (inImemReady),
    .i_branch_taken  (inBranchTaken),
    .i_branch_target (inBranchTarget),
    .i_jump          (inJump),
    .i_jump_target   (inJumpTarget),
    .o_sel           (w_sel_raw),
    .o_next_pc       (w_next_pc),
    .o_pc_plus4      (w_pc_plus4)
  );

  assign w_sel = next_pc_sel_t'(w_sel_raw);

  // HOLD covers both stall and imem-not-ready; only the latter flushes IF/ID.
  always_comb begin
    w_load_fetch  = 1'b0;
    w_load_bubble = 1'b0;
    case (w_sel)
      SEL_SEQ:               w_load_fetch  = 1'b1;
      SEL_BRANCH, SEL_JUMP:  w_load_bubble = 1'b1;
      SEL_HOLD:              w_load_bubble = !inStall;
      default:               w_load_bubble = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr   <= NOP_INSTR;
      r_post_pc <= '0;
      r_valid   <= 1'b0;
    end else if (w_load_fetch) begin
      r_instr   <= inImemData;
      r_post_pc <= w_pc_plus4;
      r_valid   <= 1'b1;
    end else if (w_load_bubble) begin
      r_instr   <= NOP_INSTR;
      r_post_pc <= '0;
      r_valid   <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_load_fetch && (r_fetch_cnt != '1)) begin
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
      if (w_load_bubble && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign outFetchCount  = r_fetch_cnt;
  assign outBubbleCount = r_bubble_cnt;
`endif

  assign outImemAddr    = r_pc;
  assign outInstruction = r_instr;
  assign outPostPc      = r_post_pc;
  assign outValid       = r_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed vectors push expectations, a monitor checks them.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        inStall;
  logic        inBranchTaken;
  logic [31:0] inBranchTarget;
  logic        inJump;
  logic [31:0] inJumpTarget;
  logic        inImemReady;
  logic [31:0] inImemData;
  logic [31:0] outImemAddr;
  logic [31:0] outInstruction;
  logic [31:0] outPostPc;
  logic        outValid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] outFetchCount;
  logic [31:0] outBubbleCount;
`endif

  if_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inStall        (inStall),
    .inBranchTaken  (inBranchTaken),
    .inBranchTarget (inBranchTarget),
    .inJump         (inJump),
    .inJumpTarget   (inJumpTarget),
    .inImemReady    (inImemReady),
    .inImemData     (inImemData),
    .outImemAddr    (outImemAddr),
    .outInstruction (outInstruction),
    .outPostPc      (outPostPc),
`ifdef IF_PERF_CNT_EN
    .outFetchCount  (outFetchCount),
    .outBubbleCount (outBubbleCount),
`endif
    .outValid       (outValid)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] post;
    logic        valid;
    int unsigned fetches;
    int unsigned bubbles;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned exp_fetch = 0;
  int unsigned exp_bub   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus plus the IF/ID state and PC expected after the next rising edge.
  task automatic step(input logic stall, input logic br, input logic [31:0] brt,
                      input logic j, input logic [31:0] jt, input logic rdy,
                      input logic [31:0] data, input logic [31:0] e_addr,
                      input logic [31:0] e_instr, input logic [31:0] e_post,
                      input logic e_valid);
    exp_t e;
    @(negedge clk);
    inStall        = stall;
    inBranchTaken  = br;
    inBranchTarget = brt;
    inJump         = j;
    inJumpTarget   = jt;
    inImemReady    = rdy;
    inImemData     = data;
    if (br || j)     exp_bub++;
    else if (!stall) begin
      if (!rdy) exp_bub++;
      else      exp_fetch++;
    end
    e.addr    = e_addr;
    e.instr   = e_instr;
    e.post    = e_post;
    e.valid   = e_valid;
    e.fetches = exp_fetch;
    e.bubbles = exp_bub;
    sb_q.push_back(e);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("imem_addr", outImemAddr, e.addr);
      check("instr", outInstruction, e.instr);
      check("post_pc", outPostPc, e.post);
      check("valid", {31'd0, outValid}, {31'd0, e.valid});
`ifdef IF_PERF_CNT_EN
      check("fetch_cnt", outFetchCount, e.fetches);
      check("bubble_cnt", outBubbleCount, e.bubbles);
`endif
    end
  end

  initial begin
    rst_n          = 1'b0;
    inStall        = 1'b1;
    inBranchTaken  = 1'b0;
    inBranchTarget = '0;
    inJump         = 1'b0;
    inJumpTarget   = '0;
    inImemReady    = 1'b0;
    inImemData     = '0;
    #3;
    check("rst_addr", outImemAddr, 32'h0);
    check("rst_instr", outInstruction, 32'h0);
    check("rst_post", outPostPc, 32'h0);
    check("rst_valid", {31'd0, outValid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //   stall br  brt           j    jt            rdy  data          addr          instr         post          v
    step(0, 0, 32'h0,         0, 32'h0,         1, 32'h2008_0001, 32'h0000_0004, 32'h2008_0001, 32'h0000_0004, 1);
    step(0, 0, 32'h0,         0, 32'h0,         1, 32'h2009_0002, 32'h0000_0008, 32'h2009_0002, 32'h0000_0008, 1);
    step(1, 0, 32'h0,         0, 32'h0,         1, 32'hDEAD_0000, 32'h0000_0008, 32'h2009_0002, 32'h0000_0008, 1);
    step(1, 0, 32'h0,         0, 32'h0,         0, 32'hDEAD_0001, 32'h0000_0008, 32'h2009_0002, 32'h0000_0008, 1);
    step(0, 0, 32'h0,         0, 32'h0,         1, 32'h200A_0003, 32'h0000_000C, 32'h200A_0003, 32'h0000_000C, 1);
    step(0, 0, 32'h0,         0, 32'h0,         1, 32'h1111_1111, 32'h0000_0010, 32'h1111_1111, 32'h0000_0010, 1);
    step(0, 0, 32'h0,         1, 32'h0040_0020, 1, 32'hDEAD_0002, 32'h0040_0020, 32'h0,         32'h0,         0);
    step(0, 0, 32'h0,         0, 32'h0,         1, 32'h2222_2222, 32'h0040_0024, 32'h2222_2222, 32'h0040_0024, 1);
    step(1, 1, 32'h0000_0100, 1, 32'h0000_0200, 1, 32'hDEAD_0003, 32'h0000_0100, 32'h0,         32'h0,         0);
    step(0, 1, 32'h0000_0023, 0, 32'h0,         0, 32'hDEAD_0004, 32'h0000_0020, 32'h0,         32'h0,         0);
    step(0, 0, 32'h0,         0, 32'h0,         0, 32'hDEAD_0005, 32'h0000_0020, 32'h0,         32'h0,         0);
    step(0, 0, 32'h0,         0, 32'h0,         1, 32'h3333_3333, 32'h0000_0024, 32'h3333_3333, 32'h0000_0024, 1);
    step(0, 1, 32'hFFFF_FFFC, 0, 32'h0,         1, 32'hDEAD_0006, 32'hFFFF_FFFC, 32'h0,         32'h0,         0);
    step(0, 0, 32'h0,         0, 32'h0,         1, 32'h4444_4444, 32'h0000_0000, 32'h4444_4444, 32'h0000_0000, 1);
    step(0, 0, 32'h0,         0, 32'h0,         1, 32'h5555_5555, 32'h0000_0004, 32'h5555_5555, 32'h0000_0004, 1);

    // Mid-cycle reset with a redirect pending: outputs clear at once, redirect is lost.
    @(negedge clk);
    inBranchTaken  = 1'b1;
    inBranchTarget = 32'h0000_0500;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_addr", outImemAddr, 32'h0);
    check("midrst_instr", outInstruction, 32'h0);
    check("midrst_post", outPostPc, 32'h0);
    check("midrst_valid", {31'd0, outValid}, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("midrst_fetch_cnt", outFetchCount, 32'h0);
    check("midrst_bubble_cnt", outBubbleCount, 32'h0);
`endif
    @(posedge clk);
    #1;
    check("rst_hold_addr", outImemAddr, 32'h0);
    @(negedge clk);
    inBranchTaken = 1'b0;
    inStall       = 1'b1;
    exp_fetch     = 0;
    exp_bub       = 0;
    rst_n         = 1'b1;
    step(0, 0, 32'h0,         0, 32'h0,         1, 32'h2008_0001, 32'h0000_0004, 32'h2008_0001, 32'h0000_0004, 1);

    begin : drain
      bit done;
      done = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #2;
        if (sb_q.size() == 0) begin
          done = 1'b1;
          break;
        end
      end
      n_checks++;
      if (!done) begin
        n_errors++;
        $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
